mem_arbiter: RTL and testbench

//  Shares the SoC's single-port memory between the CPU instruction-fetch port (I) and load/store port (D).

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 37 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_arbiter_pkg : shared types and helpers for the memory arbiter        |
// | Revision        : 1.0                                                    |
// +-------------------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic c_gnt_i = 1'b0;
  localparam logic c_gnt_d = 1'b1;

  // Counter must be able to hold the full timeout value.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_arb_timer : clear/enable cycle counter with timeout flag             |
// | Revision      : 1.0                                                      |
// +-------------------------------------------------------------------------+
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // r_cnt holds the enabled cycles already elapsed, so this flags the
  // TIMEOUT_CYCLES-th enabled cycle itself.
  assign o_expired = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between CPU fetch (I) and data (D) |
// |               ports, with a bus timeout. Define MEM_ARB_RR_EN for       |
// |               round-robin tie-breaking (default: D over I).             |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    btn2,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    bus_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  localparam int CNT_W = timer_width(TIMEOUT_CYCLES);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_gnt;
  logic       w_any_req;
  logic       w_prefer_d;
  logic       w_pick;
  logic       w_take;
  logic       w_done;
  logic       w_expired;

  assign w_any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  logic r_last_gnt;

  always_ff @(posedge clk or negedge btn2) begin
    if (!btn2) begin
      r_last_gnt <= c_gnt_i;
    end else if (w_take) begin
      r_last_gnt <= w_pick;
    end
  end

  // On a tie the port not served last wins.
  assign w_prefer_d = (r_last_gnt == c_gnt_i);
`else
  assign w_prefer_d = 1'b1;
`endif

  assign w_pick = (d_req && (!i_req || w_prefer_d)) ? c_gnt_d : c_gnt_i;

  always_ff @(posedge clk or negedge btn2) begin
    if (!btn2) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_take      = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (mem_ready || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  mem_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (btn2),
    .i_clear   (r_state != ST_GRANT),
    .i_en      (r_state == ST_GRANT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge btn2) begin
    if (!btn2) begin
      r_gnt     <= c_gnt_i;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_req <= (w_state_nxt == ST_GRANT);
      i_ready <= w_done && (r_gnt == c_gnt_i);
      d_ready <= w_done && (r_gnt == c_gnt_d);
      // mem_ready takes precedence over a coincident timeout.
      bus_err <= w_done && !mem_ready;

      if (w_take) begin
        r_gnt <= w_pick;
        if (w_pick == c_gnt_d) begin
          mem_we    <= d_we;
          mem_wstrb <= d_we ? d_wstrb : '0;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_wstrb <= '0;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end

      if (w_done) begin
        if (r_gnt == c_gnt_i) begin
          i_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter                        |
// | Revision       : 1.0                                                     |
// +-------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk  = 1'b0;
  logic          btn2 = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [SW-1:0] d_wstrb = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .btn2      (btn2),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wstrb   (d_wstrb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Memory model: ready after 'lat' extra request cycles, never when hung.
  int lat  = 1;
  bit hang = 1'b0;
  int mcnt = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_ready = mem_req && !hang && (mcnt >= lat);
  assign mem_rdata = mem_ready ? mem_val(mem_addr) : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (!mem_req || mem_ready) mcnt <= 0;
    else                       mcnt <= mcnt + 1;
  end

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   tb_last_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks every grant and every completion against the queues.
  logic mon_prev_req = 1'b0;
  bit   mon_busy     = 1'b0;
  gnt_t mon_g;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (!btn2) begin
      mon_prev_req = 1'b0;
      mon_busy     = 1'b0;
    end else begin
      if (mem_req && !mon_prev_req) begin
        check("no_grant_without_resp", {63'd0, mon_busy}, 64'd0);
        mon_busy = 1'b1;
        check("grant_expected", {63'd0, gnt_q.size() != 0}, 64'd1);
        if (gnt_q.size() != 0) begin
          mon_g = gnt_q.pop_front();
          check("mem_we", {63'd0, mem_we}, {63'd0, mon_g.we});
          check("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, mon_g.wstrb});
          check("mem_addr", {32'd0, mem_addr}, {32'd0, mon_g.addr});
          if (mon_g.chk_wdata) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, mon_g.wdata});
        end
      end
      if (i_ready || d_ready) begin
        mon_busy = 1'b0;
        check("single_ready", {63'd0, i_ready & d_ready}, 64'd0);
        check("ready_expected", {63'd0, rsp_q.size() != 0}, 64'd1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          check("ready_port", {63'd0, d_ready}, {63'd0, mon_r.port});
          check("rdata", {32'd0, (d_ready ? d_rdata : i_rdata)}, {32'd0, mon_r.rdata});
          check("bus_err", {63'd0, bus_err}, {63'd0, mon_r.err});
        end
      end
      mon_prev_req = mem_req;
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic push_fetch(input logic [31:0] a, input bit err);
    rsp_q.push_back('{1'b0, (err ? 32'd0 : mem_val(a)), err});
    gnt_q.push_back('{1'b0, 4'd0, a, 32'd0, 1'b0});
  endtask

  task automatic push_data(input bit we, input logic [3:0] st, input logic [31:0] a,
                           input logic [31:0] wd);
    rsp_q.push_back('{1'b1, (we ? 32'd0 : mem_val(a)), 1'b0});
    gnt_q.push_back('{we, (we ? st : 4'd0), a, wd, we});
  endtask

  // Counts cycles from request to the port's ready pulse, then drops req.
  task automatic wait_ready(input bit port_d, input int exp_cyc, input int exp_req,
                            input string name);
    int n = 0;
    int nreq = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_req) nreq++;
      if (port_d ? d_ready : i_ready) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_cyc));
    check({name, "_mem_req_cycles"}, 64'(nreq), 64'(exp_req));
    if (port_d) d_req = 1'b0;
    else        i_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit err, input int exp_cyc,
                       input int exp_req, input string name);
    idle(1);
    i_addr = a;
    i_req  = 1'b1;
    push_fetch(a, err);
    tb_last_d = 1'b0;
    wait_ready(1'b0, exp_cyc, exp_req, name);
  endtask

  task automatic data(input bit we, input logic [3:0] st, input logic [31:0] a,
                      input logic [31:0] wd, input string name);
    idle(1);
    d_we    = we;
    d_wstrb = st;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    push_data(we, st, a, wd);
    tb_last_d = 1'b1;
    wait_ready(1'b1, 3, 2, name);
  endtask

  // Both ports request together and hold until served.
  task automatic tie(input logic [31:0] ia, input logic [31:0] da, input string name);
    bit d_first;
    int n = 0;
`ifdef MEM_ARB_RR_EN
    d_first = !tb_last_d;
`else
    d_first = 1'b1;
`endif
    idle(1);
    i_addr = ia; d_addr = da; d_we = 1'b0; d_wstrb = 4'hF; d_wdata = 32'h1234_5678;
    i_req = 1'b1; d_req = 1'b1;
    if (d_first) begin
      push_data(1'b0, 4'h0, da, 32'd0);
      push_fetch(ia, 1'b0);
    end else begin
      push_fetch(ia, 1'b0);
      push_data(1'b0, 4'h0, da, 32'd0);
    end
    tb_last_d = !d_first;
    while ((i_req || d_req) && n < 100) begin
      @(negedge clk);
      n++;
      if (i_ready) i_req = 1'b0;
      if (d_ready) d_req = 1'b0;
    end
    check({name, "_cycles"}, 64'(n), 64'd7);
  endtask

  initial begin
    int n;
    int busy;

    // Reset state
    idle(3);
    check("reset_ctrl", {58'd0, mem_req, mem_we, mem_wstrb, i_ready, d_ready, bus_err}, 64'd0);
    check("reset_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    check("reset_rdata", {i_rdata, d_rdata}, 64'd0);
    btn2 = 1'b1;
    idle(2);

    // Fetch, store, load with one-cycle memory latency
    lat = 1;
    fetch(32'h10, 1'b0, 3, 2, "fetch");
    data(1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, "store");
    data(1'b0, 4'b1111, 32'h24, 32'hFFFF_FFFF, "load");

    // Ties: order depends on arbitration mode and the last served port
    tie(32'h30, 32'h34, "tie1");
    tie(32'h38, 32'h3C, "tie2");
    data(1'b0, 4'h0, 32'h44, 32'h0, "load_before_tie");
    tie(32'h48, 32'h4C, "tie3");

    // Timeout, and mem_ready arriving in the final allowed cycle
    hang = 1'b1;
    fetch(32'h50, 1'b1, TO + 1, TO, "timeout");
    hang = 1'b0;
    lat  = TO - 1;
    fetch(32'h54, 1'b0, TO + 1, TO, "late_ready");

    // Asynchronous reset in the middle of a granted access
    lat  = 1;
    hang = 1'b1;
    idle(1);
    i_addr = 32'h60;
    i_req  = 1'b1;
    gnt_q.push_back('{1'b0, 4'd0, 32'h60, 32'd0, 1'b0});
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_granted", {63'd0, mem_req}, 64'd1);
    idle(2);
    #2 btn2 = 1'b0;
    #1;
    check("mid_reset_ctrl", {58'd0, mem_req, mem_we, mem_wstrb, i_ready, d_ready, bus_err}, 64'd0);
    check("mid_reset_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    check("mid_reset_rdata", {i_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    i_req = 1'b0;
    hang  = 1'b0;
    tb_last_d = 1'b0;
    idle(2);
    btn2 = 1'b1;
    busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_req || i_ready || d_ready) busy++;
    end
    check("idle_after_reset", 64'(busy), 64'd0);

    // Back-to-back fetches, memory ready in the first request cycle
    lat = 0;
    idle(1);
    for (int k = 0; k < 4; k++) push_fetch(32'h100 + 32'(4 * k), 1'b0);
    i_addr = 32'h100;
    i_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!i_ready && n < 20);
      check("b2b_interval", 64'(n), (k == 0) ? 64'd2 : 64'd3);
      if (k < 3) i_addr = 32'h100 + 32'(4 * (k + 1));
      else       i_req  = 1'b0;
    end
    idle(6);

    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
